// File: rtl/charge_credit_ctrl_pkg.sv
// Shared types and constants for the charging-station credit controller.
// The optional refund path is selected with the CHARGE_REFUND_EN macro.
package charge_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCEPT,
      CHARGING,
      DONE
   } state_t;

   localparam logic [2:0] COIN_1  = 3'b001;
   localparam logic [2:0] COIN_5  = 3'b101;
   localparam logic [2:0] COIN_10 = 3'b010;

   localparam logic [3:0] VAL_1  = 4'd1;
   localparam logic [3:0] VAL_5  = 4'd5;
   localparam logic [3:0] VAL_10 = 4'd10;

   localparam logic [3:0] MODE_NONE = 4'b0000;
   localparam logic [3:0] MODE_SLOW = 4'b0001;
   localparam logic [3:0] MODE_FAST = 4'b0101;

   // Zero marks an unrecognised coin code.
   function automatic logic [3:0] coin_value(input logic [2:0] code);
      logic [3:0] v;
      v = 4'd0;
      case (code)
         COIN_1:  v = VAL_1;
         COIN_5:  v = VAL_5;
         COIN_10: v = VAL_10;
         default: v = 4'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/charge_timer.sv
// Loadable down-counter for session seconds.
// Uses the CHARGE_REFUND_EN-independent timing path of charge_credit_ctrl.
module charge_timer #(
   parameter int TIME_W = 16
) (
   input  logic              clk,
   input  logic              nReset,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic              i_tick,
   input  logic [TIME_W-1:0] i_load_val,
   output logic [TIME_W-1:0] o_count,
   output logic              o_zero_next
);

   logic [TIME_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!nReset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_tick && (r_count != '0)) begin
         r_count <= r_count - TIME_W'(1);
      end
   end

   assign o_count     = r_count;
   assign o_zero_next = (r_count == TIME_W'(1));

endmodule

// File: rtl/charge_credit_ctrl.sv
// Coin credit accumulator and timed charge-session controller.
// Define CHARGE_REFUND_EN to return unspent credit on cancel in ACCEPT.
module charge_credit_ctrl
   import charge_pkg::*;
#(
   parameter int CREDIT_W    = 8,
   parameter int MAX_CREDIT  = 50,
   parameter int MIN_CREDIT  = 1,
   parameter int FAST_THRESH = 5,
   parameter int SEC_SLOW    = 60,
   parameter int SEC_FAST    = 90,
   parameter int TIME_W      = 16
) (
   input  logic                clk,
   input  logic                nReset,
   input  logic                tick,
   input  logic                coin_valid,
   input  logic [2:0]          coin_code,
   input  logic                start,
   input  logic                cancel,
   output logic [CREDIT_W-1:0] credit,
   output logic [3:0]          mode,
   output logic                charging,
   output logic [TIME_W-1:0]   time_left,
   output logic                coin_reject,
   output logic                done,
   output logic                refund_valid,
   output logic [CREDIT_W-1:0] refund_amount
);

   state_t              r_state, w_state_nxt;
   logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
   logic [3:0]          r_mode, w_mode_nxt;
   logic                r_charging, w_charging_nxt;
   logic                r_coin_reject, w_reject;
   logic                r_done, w_done_nxt;

   logic [3:0]          w_coin_val;
   logic [CREDIT_W:0]   w_sum;
   logic                w_coin_fits;
   logic [3:0]          w_mode_cur;
   logic [TIME_W-1:0]   w_load_val;
   logic                w_load, w_clear, w_tick_en, w_zero_next;
   logic                w_cancel_acc, w_refund;

   assign w_coin_val  = coin_value(coin_code);
   assign w_sum       = {1'b0, r_credit} + (CREDIT_W+1)'(w_coin_val);
   assign w_coin_fits = (w_coin_val != 4'd0)
                     && (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));

   assign w_mode_cur = (r_credit == '0) ? MODE_NONE :
                       (r_credit < CREDIT_W'(FAST_THRESH)) ? MODE_SLOW :
                       MODE_FAST;

   assign w_load_val = (w_mode_cur == MODE_FAST)
                     ? TIME_W'(r_credit) * TIME_W'(SEC_FAST)
                     : TIME_W'(r_credit) * TIME_W'(SEC_SLOW);

`ifdef CHARGE_REFUND_EN
   assign w_cancel_acc = cancel && (r_credit != '0);
`else
   assign w_cancel_acc = 1'b0;
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_credit_nxt   = r_credit;
      w_mode_nxt     = r_mode;
      w_charging_nxt = r_charging;
      w_reject       = 1'b0;
      w_done_nxt     = 1'b0;
      w_load         = 1'b0;
      w_clear        = 1'b0;
      w_tick_en      = 1'b0;
      w_refund       = 1'b0;
      unique case (r_state)
         IDLE, ACCEPT: begin
            if ((r_state == ACCEPT) && w_cancel_acc) begin
               w_refund     = 1'b1;
               w_credit_nxt = '0;
               w_state_nxt  = IDLE;
            end else if (coin_valid) begin
               if (w_coin_fits) begin
                  w_credit_nxt = w_sum[CREDIT_W-1:0];
                  w_state_nxt  = ACCEPT;
               end else begin
                  w_reject = 1'b1;
               end
            end else if ((r_state == ACCEPT) && start
                         && (r_credit >= CREDIT_W'(MIN_CREDIT))) begin
               w_load         = 1'b1;
               w_credit_nxt   = '0;
               w_mode_nxt     = w_mode_cur;
               w_charging_nxt = 1'b1;
               w_state_nxt    = CHARGING;
            end
         end
         CHARGING: begin
            if (cancel) begin
               w_clear        = 1'b1;
               w_charging_nxt = 1'b0;
               w_mode_nxt     = MODE_NONE;
               w_done_nxt     = 1'b1;
               w_state_nxt    = DONE;
            end else begin
               w_reject = coin_valid;
               if (tick) begin
                  w_tick_en = 1'b1;
                  if (w_zero_next) begin
                     w_charging_nxt = 1'b0;
                     w_mode_nxt     = MODE_NONE;
                     w_done_nxt     = 1'b1;
                     w_state_nxt    = DONE;
                  end
               end
            end
         end
         DONE: begin
            w_reject    = coin_valid;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nReset) begin
         r_state       <= IDLE;
         r_credit      <= '0;
         r_mode        <= MODE_NONE;
         r_charging    <= 1'b0;
         r_coin_reject <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_credit      <= w_credit_nxt;
         r_mode        <= w_mode_nxt;
         r_charging    <= w_charging_nxt;
         r_coin_reject <= w_reject;
         r_done        <= w_done_nxt;
      end
   end

   charge_timer #(
      .TIME_W(TIME_W)
   ) u_timer (
      .clk        (clk),
      .nReset     (nReset),
      .i_load     (w_load),
      .i_clear    (w_clear),
      .i_tick     (w_tick_en),
      .i_load_val (w_load_val),
      .o_count    (time_left),
      .o_zero_next(w_zero_next)
   );

`ifdef CHARGE_REFUND_EN
   logic                r_refund_valid;
   logic [CREDIT_W-1:0] r_refund_amount;

   always_ff @(posedge clk) begin
      if (!nReset) begin
         r_refund_valid  <= 1'b0;
         r_refund_amount <= '0;
      end else begin
         r_refund_valid <= w_refund;
         if (w_refund) begin
            r_refund_amount <= r_credit;
         end
      end
   end

   assign refund_valid  = r_refund_valid;
   assign refund_amount = r_refund_amount;
`else
   logic w_unused_refund;
   assign w_unused_refund = w_refund;
   assign refund_valid    = 1'b0;
   assign refund_amount   = '0;
`endif

   // Mode follows live credit until a session latches it.
   assign mode = ((r_state == IDLE) || (r_state == ACCEPT))
               ? w_mode_cur : r_mode;

   assign credit      = r_credit;
   assign charging    = r_charging;
   assign coin_reject = r_coin_reject;
   assign done        = r_done;

endmodule

// File: tb/tb_charge_credit_ctrl.sv
// Randomised and directed bench for charge_credit_ctrl.
// Follows CHARGE_REFUND_EN when the same macro is set for the build.
module tb_charge_credit_ctrl;

   logic        clk = 1'b0;
   logic        nReset;
   logic        tick, coin_valid, start, cancel;
   logic [2:0]  coin_code;
   logic [7:0]  credit;
   logic [3:0]  mode;
   logic        charging;
   logic [15:0] time_left;
   logic        coin_reject, done, refund_valid;
   logic [7:0]  refund_amount;

   int n_cmp = 0;
   int n_err = 0;

`ifdef CHARGE_REFUND_EN
   localparam bit REFUND = 1'b1;
`else
   localparam bit REFUND = 1'b0;
`endif

   // Behavioural model: session phase plus plain integer bookkeeping.
   localparam int P_IDLE = 0, P_ACC = 1, P_CHG = 2, P_END = 3;
   int ph, m_credit, m_smode, m_tl, m_chg, m_rej, m_done, m_rv, m_ra;

   charge_credit_ctrl dut (
      .clk          (clk),
      .nReset       (nReset),
      .tick         (tick),
      .coin_valid   (coin_valid),
      .coin_code    (coin_code),
      .start        (start),
      .cancel       (cancel),
      .credit       (credit),
      .mode         (mode),
      .charging     (charging),
      .time_left    (time_left),
      .coin_reject  (coin_reject),
      .done         (done),
      .refund_valid (refund_valid),
      .refund_amount(refund_amount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_mode();
      if (ph == P_IDLE || ph == P_ACC)
         return (m_credit == 0) ? 0 : (m_credit < 5) ? 1 : 5;
      if (ph == P_CHG) return m_smode;
      return 0;
   endfunction

   task automatic check_all();
      check("credit", credit, m_credit);
      check("mode", mode, exp_mode());
      check("charging", charging, m_chg);
      check("time_left", time_left, m_tl);
      check("coin_reject", coin_reject, m_rej);
      check("done", done, m_done);
      check("refund_valid", refund_valid, m_rv);
      check("refund_amount", refund_amount, m_ra);
   endtask

   task automatic model_reset();
      ph = P_IDLE; m_credit = 0; m_smode = 0; m_tl = 0; m_chg = 0;
      m_rej = 0; m_done = 0; m_rv = 0; m_ra = 0;
   endtask

   task automatic model_step(input bit cv, input int code, input bit st,
                             input bit cn, input bit tk);
      int val;
      val = (code == 1) ? 1 : (code == 5) ? 5 : (code == 2) ? 10 : 0;
      m_rej = 0; m_done = 0; m_rv = 0;
      case (ph)
         P_IDLE, P_ACC: begin
            if (ph == P_ACC && cn && REFUND && m_credit > 0) begin
               m_rv = 1; m_ra = m_credit; m_credit = 0; ph = P_IDLE;
            end else if (cv) begin
               if (val > 0 && m_credit + val <= 50) begin
                  m_credit += val; ph = P_ACC;
               end else m_rej = 1;
            end else if (ph == P_ACC && st && m_credit >= 1) begin
               m_smode = (m_credit >= 5) ? 5 : 1;
               m_tl = m_credit * ((m_credit >= 5) ? 90 : 60);
               m_credit = 0; m_chg = 1; ph = P_CHG;
            end
         end
         P_CHG: begin
            if (cn) begin
               m_tl = 0; m_chg = 0; m_done = 1; ph = P_END;
            end else begin
               m_rej = cv;
               if (tk) begin
                  m_tl--;
                  if (m_tl == 0) begin
                     m_chg = 0; m_done = 1; ph = P_END;
                  end
               end
            end
         end
         default: begin
            m_rej = cv; ph = P_IDLE;
         end
      endcase
   endtask

   task automatic cycle(input bit cv, input int code, input bit st,
                        input bit cn, input bit tk);
      @(negedge clk);
      nReset = 1'b1; coin_valid = cv; coin_code = 3'(code);
      start = st; cancel = cn; tick = tk;
      model_step(cv, code, st, cn, tk);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      nReset = 1'b0; coin_valid = 0; coin_code = 0;
      start = 0; cancel = 0; tick = 0;
      model_reset();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic coin(input int code);
      cycle(1, code, 0, 0, 0);
   endtask

   initial begin
      do_reset();
      check("rst_credit", credit, 0);
      check("rst_time", time_left, 0);

      // 1, 5, 1 then start: 7 pesos fast -> 630 s
      coin(1); check("c1", credit, 1); check("m1", mode, 1);
      coin(5); check("c6", credit, 6); check("m6", mode, 5);
      coin(1); check("c7", credit, 7);
      cycle(0, 0, 1, 0, 0);
      check("tl630", time_left, 630); check("chg_on", charging, 1);
      cycle(0, 0, 0, 1, 0);
      check("cancel_done", done, 1);
      cycle(0, 0, 0, 0, 0);

      // Overflow boundary at 48 + 5
      for (int i = 0; i < 4; i++) coin(2);
      coin(5); coin(1); coin(1); coin(1);
      check("c48", credit, 48);
      coin(5); check("rej53", coin_reject, 1); check("c48b", credit, 48);
      coin(1); check("c49", credit, 49);
      cycle(0, 0, 1, 0, 0); check("tl4410", time_left, 4410);
      cycle(1, 1, 0, 0, 1); check("rej_chg", coin_reject, 1);
      cycle(0, 0, 0, 1, 0); cycle(0, 0, 0, 0, 0);

      // Invalid code in IDLE; start in IDLE ignored
      coin(7); check("rej7", coin_reject, 1); check("c0", credit, 0);
      cycle(0, 0, 1, 0, 0); check("idle_start", charging, 0);

      // Slow session of 2 pesos runs out after 120 ticks
      coin(1); coin(1);
      cycle(0, 0, 1, 0, 0); check("tl120", time_left, 120);
      for (int i = 0; i < 120; i++) cycle(0, 0, 0, 0, 1);
      check("done120", done, 1); check("tl0", time_left, 0);
      cycle(0, 0, 0, 0, 1); check("done_once", done, 0);

      // Cancel with 5 pesos in ACCEPT
      coin(5); cycle(0, 0, 0, 1, 0);
      check("cancel_acc", credit, REFUND ? 0 : 5);
      check("refund", refund_amount, REFUND ? 5 : 0);
      if (REFUND) coin(5);
      // Reset mid-session at 300 s left
      cycle(0, 0, 1, 0, 0);
      for (int i = 0; i < 150; i++) cycle(0, 0, 0, 0, 1);
      check("tl300", time_left, 300);
      do_reset();
      check("rst_chg", charging, 0); check("rst_tl", time_left, 0);

      // Coin plus start in ACCEPT adds the coin only
      coin(1); cycle(1, 1, 1, 0, 0);
      check("cs_credit", credit, 2); check("cs_chg", charging, 0);

      repeat (3000) begin
         int r, code;
         bit cv, st, cn, tk;
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            r = $urandom_range(0, 9);
            code = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7)
                 : (($urandom_range(0, 2) == 0) ? 1 :
                    ($urandom_range(0, 1) == 0) ? 5 : 2);
            cv = (r < 4); st = (r == 4 || r == 5); cn = (r == 6);
            tk = ($urandom_range(0, 1) == 1);
            cycle(cv, code, st, cn, tk);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/charge_credit_ctrl.md
# charge_credit_ctrl

Credit accumulator and charge-session controller for the coin-operated charging station. It sums validated coin pulses into a bounded credit, selects the charge mode tier from that credit, and runs a timed charging session on a 1 Hz tick. An optional refund path returns unspent credit on cancel. It sits between the coin acceptor front end and the relay/display drivers, and supersedes the combinational coin-to-mode selection.

## Interface
- CREDIT_W, 8: credit register width in pesos
- MAX_CREDIT, 50: highest credit accepted; coins that would exceed it are rejected
- MIN_CREDIT, 1: minimum credit that lets start begin a session
- FAST_THRESH, 5: credit at or above this value selects fast mode
- SEC_SLOW, 60: seconds of charge per peso in slow mode
- SEC_FAST, 90: seconds of charge per peso in fast mode
- TIME_W, 16: width of time_left; sized by the integrator so that MAX_CREDIT*SEC_FAST fits
- clk  in  1  system clock
- nReset  in  1  reset, synchronous, active-low
- tick  in  1  one-cycle 1 Hz enable pulse
- coin_valid  in  1  one-cycle strobe; coin_code is valid
- coin_code  in  3  3'b001 = 1 peso, 3'b101 = 5 peso, 3'b010 = 10 peso, all other codes invalid
- start  in  1  user start pulse
- cancel  in  1  user cancel pulse
- credit  out  CREDIT_W  accumulated credit
- mode  out  4  4'b0000 none, 4'b0001 slow, 4'b0101 fast
- charging  out  1  relay enable
- time_left  out  TIME_W  remaining session seconds
- coin_reject  out  1  one-cycle pulse when a coin is refused
- done  out  1  one-cycle pulse at session end
- refund_valid  out  1  one-cycle pulse (CHARGE_REFUND_EN only)
- refund_amount  out  CREDIT_W  credit being returned; held until the next refund

## Operation
- States: IDLE, ACCEPT, CHARGING, DONE.
- IDLE: a valid coin adds its value to credit and moves to ACCEPT. An invalid code raises coin_reject and stays in IDLE.
- ACCEPT:
  - A valid coin adds its value to credit if credit + value ≤ MAX_CREDIT. Otherwise coin_reject fires and credit is unchanged. An invalid code raises coin_reject.
  - start with credit ≥ MIN_CREDIT moves to CHARGING.
  - start with credit < MIN_CREDIT is ignored.
- mode is combinational from credit in IDLE and ACCEPT: 0 gives 4'b0000, below FAST_THRESH gives 4'b0001, otherwise 4'b0101. mode is latched on entry to CHARGING and held until DONE.
- Entry to CHARGING:
  - time_left = credit*SEC_FAST if fast, else credit*SEC_SLOW.
  - Multiply at TIME_W width.
  - credit is cleared and charging = 1.
- CHARGING:
  - Each tick decrements time_left.
  - A tick while time_left == 1 moves to DONE.
  - Coins are rejected with coin_reject.
  - cancel moves to DONE with time_left cleared; no refund is given.
- DONE: done = 1 for one cycle, charging = 0, mode = 0, then IDLE.
- Priority within a single cycle: cancel > coin > start. A coin and start in the same cycle adds the coin and ignores start.

## Timing
- Every output except mode in IDLE/ACCEPT is registered. A coin is reflected in credit on the cycle after coin_valid.
- Latencies:
  - start to charging high: 1 cycle.
  - Final tick to done: 1 cycle.
  - done to IDLE: 1 cycle.
- Reset values: credit 0, mode 0, charging 0, time_left 0, coin_reject 0, done 0, refund_valid 0, refund_amount 0, state IDLE.
- nReset mid-session returns everything to reset values immediately. Credit is lost and no refund is given.

## Configuration
- CHARGE_REFUND_EN defined:
  - cancel in ACCEPT with credit > 0 pulses refund_valid.
  - refund_amount takes the credit value, credit clears, and the state returns to IDLE.
- CHARGE_REFUND_EN undefined:
  - refund_valid and refund_amount are tied to 0.
  - cancel in ACCEPT is ignored and credit is retained.
- CHARGING behaviour is the same in both builds.

## Structure
- Package charge_pkg holds:
  - State enum.
  - Coin code constants COIN_1, COIN_5, COIN_10 and their values.
  - Mode constants MODE_NONE, MODE_SLOW, MODE_FAST.
- Sub-module charge_timer: a TIME_W loadable down-counter with load, tick, and a zero-next flag. The FSM, coin adder and mode logic stay in the top level.

## Test plan
- Coins 1, 5, 1, then start: credit goes 1, 6, 7. Mode goes 0001, 0101, 0101. The session starts with time_left = 630 (default parameters) and charging high one cycle after start.
- Credit 48, then a 5-peso coin: coin_reject pulses and credit stays 48. A following 1-peso coin gives 49.
- coin_code 3'b111: coin_reject pulses and the state stays IDLE with credit 0.
- Credit 2 (slow), start, then 120 ticks: time_left reaches 0, done pulses once, charging drops, and the state returns to IDLE.
- Credit 5 with CHARGE_REFUND_EN: cancel gives refund_valid with refund_amount = 5 and credit 0. The same stimulus without the macro leaves credit at 5 and still in ACCEPT.
- nReset low during CHARGING (time_left 300): the next cycle shows all outputs at reset values. A coin and start in the same cycle in ACCEPT adds the coin only.
